// File: rtl/rtc_pulse_gen_pkg.sv
// rtc_pulse_gen_pkg: shared RTC constants, time type, channel state encoding and time adder
package rtc_pulse_gen_pkg;
  localparam logic [31:0] NS_PER_S = 32'd1_000_000_000;
  typedef enum logic [1:0] {PG_IDLE, PG_ALIGN, PG_ARMED, PG_HIGH} pg_state_e;
  typedef struct packed {
    logic [47:0] sc;
    logic [31:0] ns;
  } rtc_t;
  // Single conditional subtract: operands are expected to keep ns below 2*NS_PER_S
  function automatic rtc_t rtc_add(rtc_t t, logic [47:0] p_sc, logic [31:0] p_ns);
    logic [32:0] s;
    logic wrap;
    s = {1'b0, t.ns} + {1'b0, p_ns};
    wrap = s >= {1'b0, NS_PER_S};
    rtc_add.sc = t.sc + p_sc + 48'(wrap);
    rtc_add.ns = wrap ? 32'(s - {1'b0, NS_PER_S}) : s[31:0];
  endfunction
endpackage

// File: rtl/rtc_pulse_gen_if.sv
// rtc_pulse_gen_if: RTC time, per-channel config and pulse outputs; RTC_PG_TS_EN adds edge timestamps
interface rtc_pulse_gen_if #(parameter int NUM_CH = 4);
  import rtc_pulse_gen_pkg::*;
  logic [79:0]         rtc_std_i;
  logic                rtc_step_i;
  logic [NUM_CH-1:0]   ch_en_i;
  logic [NUM_CH*48-1:0] start_sc_i;
  logic [NUM_CH*32-1:0] start_ns_i;
  logic [NUM_CH*16-1:0] period_sc_i;
  logic [NUM_CH*30-1:0] period_ns_i;
  logic [NUM_CH*32-1:0] width_ns_i;
  logic [NUM_CH-1:0]   pulse_o;
  logic [NUM_CH-1:0]   align_o;
  logic [NUM_CH-1:0]   missed_o;
`ifdef RTC_PG_TS_EN
  logic [NUM_CH*80-1:0] edge_ts_o;
  logic [NUM_CH-1:0]   edge_ts_vld_o;
  modport master(output rtc_std_i, rtc_step_i, ch_en_i, start_sc_i, start_ns_i, period_sc_i, period_ns_i,
                 width_ns_i, input pulse_o, align_o, missed_o, edge_ts_o, edge_ts_vld_o);
  modport slave(input rtc_std_i, rtc_step_i, ch_en_i, start_sc_i, start_ns_i, period_sc_i, period_ns_i,
                width_ns_i, output pulse_o, align_o, missed_o, edge_ts_o, edge_ts_vld_o);
`else
  modport master(output rtc_std_i, rtc_step_i, ch_en_i, start_sc_i, start_ns_i, period_sc_i, period_ns_i,
                 width_ns_i, input pulse_o, align_o, missed_o);
  modport slave(input rtc_std_i, rtc_step_i, ch_en_i, start_sc_i, start_ns_i, period_sc_i, period_ns_i,
                width_ns_i, output pulse_o, align_o, missed_o);
`endif
endinterface

// File: rtl/rtc_pulse_gen_chan.sv
// rtc_pulse_gen_chan: one pulse channel FSM with target/fall adders and 80-bit time comparators
module rtc_pulse_gen_chan
  import rtc_pulse_gen_pkg::*;
(
  input  logic        rtc_clk,
  input  logic        rtc_rst_n,
  input  rtc_t        rtc_std,
  input  logic        rtc_step,
  input  logic        en,
  input  logic [47:0] start_sc,
  input  logic [31:0] start_ns,
  input  logic [15:0] period_sc,
  input  logic [29:0] period_ns,
  input  logic [31:0] width_ns,
  output logic        pulse,
  output logic        align,
  output logic        missed
`ifdef RTC_PG_TS_EN
  ,
  output rtc_t        edge_ts,
  output logic        edge_ts_vld
`endif
);
  pg_state_e st;
  logic en_q;
  rtc_t start, target, fall;
  logic [15:0] p_sc;
  logic [29:0] p_ns;
  logic [31:0] wid;
  rtc_t tgt_next, fall_next;
  logic tgt_hit, fall_hit;
  assign tgt_next  = rtc_add(target, {32'd0, p_sc}, {2'd0, p_ns});
  assign fall_next = rtc_add(target, 48'd0, wid);
  assign tgt_hit   = rtc_std >= target;
  assign fall_hit  = rtc_std >= fall;
  assign align     = st == PG_ALIGN;
  // Enable drop beats a same-cycle step; steps restart alignment from the latched start
  always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
    if (!rtc_rst_n) begin
      st     <= PG_IDLE;
      en_q   <= 1'b0;
      start  <= '0;
      target <= '0;
      fall   <= '0;
      p_sc   <= '0;
      p_ns   <= '0;
      wid    <= '0;
      pulse  <= 1'b0;
      missed <= 1'b0;
`ifdef RTC_PG_TS_EN
      edge_ts     <= '0;
      edge_ts_vld <= 1'b0;
`endif
    end else begin
      en_q <= en;
`ifdef RTC_PG_TS_EN
      edge_ts_vld <= 1'b0;
`endif
      if (!en) begin
        st    <= PG_IDLE;
        pulse <= 1'b0;
      end else if (st == PG_IDLE) begin
        if (!en_q) begin
          start  <= {start_sc, start_ns};
          target <= {start_sc, start_ns};
          p_sc   <= period_sc;
          p_ns   <= period_ns;
          wid    <= width_ns;
          missed <= 1'b0;
          st     <= PG_ALIGN;
        end
      end else if (rtc_step) begin
        pulse  <= 1'b0;
        target <= start;
        st     <= PG_ALIGN;
      end else if (st == PG_ALIGN) begin
        if (tgt_hit) begin
          target <= tgt_next;
          missed <= 1'b1;
        end else st <= PG_ARMED;
      end else if (st == PG_ARMED) begin
        if (tgt_hit) begin
          target <= tgt_next;
          if (wid != 32'd0) begin
            pulse <= 1'b1;
            fall  <= fall_next;
            st    <= PG_HIGH;
`ifdef RTC_PG_TS_EN
            edge_ts     <= rtc_std;
            edge_ts_vld <= 1'b1;
`endif
          end
        end
      end else if (fall_hit || tgt_hit) begin
        pulse <= 1'b0;
        st    <= PG_ARMED;
      end
    end
  end
endmodule

// File: rtl/rtc_pulse_gen.sv
// rtc_pulse_gen: NUM_CH programmable pulse channels off the PTP RTC; RTC_PG_TS_EN adds rise timestamps
module rtc_pulse_gen
  import rtc_pulse_gen_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input logic           rtc_clk,
  input logic           rtc_rst_n,
  rtc_pulse_gen_if.slave bus
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    rtc_pulse_gen_chan u_ch (
      .rtc_clk   (rtc_clk),
      .rtc_rst_n (rtc_rst_n),
      .rtc_std   (bus.rtc_std_i),
      .rtc_step  (bus.rtc_step_i),
      .en        (bus.ch_en_i[i]),
      .start_sc  (bus.start_sc_i[i*48 +: 48]),
      .start_ns  (bus.start_ns_i[i*32 +: 32]),
      .period_sc (bus.period_sc_i[i*16 +: 16]),
      .period_ns (bus.period_ns_i[i*30 +: 30]),
      .width_ns  (bus.width_ns_i[i*32 +: 32]),
      .pulse     (bus.pulse_o[i]),
      .align     (bus.align_o[i]),
      .missed    (bus.missed_o[i])
`ifdef RTC_PG_TS_EN
      ,
      .edge_ts     (bus.edge_ts_o[i*80 +: 80]),
      .edge_ts_vld (bus.edge_ts_vld_o[i])
`endif
    );
  end
endmodule

// File: tb/tb_rtc_pulse_gen.sv
// tb_rtc_pulse_gen: ns-domain reference model with per-cycle compare plus directed literal checks
module tb_rtc_pulse_gen;
  localparam int N = 4;
  localparam longint NS = 64'd1_000_000_000;
  logic rtc_clk = 1'b0;
  logic rtc_rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  rtc_pulse_gen_if #(.NUM_CH(N)) bus ();
  rtc_pulse_gen #(.NUM_CH(N)) dut (.rtc_clk(rtc_clk), .rtc_rst_n(rtc_rst_n), .bus(bus));
  always #3 rtc_clk = ~rtc_clk;
  int     m_mode[N];
  longint m_start[N], m_per[N], m_w[N], m_tgt[N], m_fall[N], m_ts[N];
  logic   m_pulse[N], m_missed[N], m_en_prev[N], m_vld[N];
  function automatic logic [79:0] to80(longint t);
    return {48'(t / NS), 32'(t % NS)};
  endfunction
  task automatic chk(string nm, logic [79:0] act, logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick(longint t);
    bus.rtc_std_i = to80(t);
    @(posedge rtc_clk);
    #1;
  endtask
  task automatic cfg(int c, longint st, longint per, longint w);
    bus.start_sc_i[c*48 +: 48]  = 48'(st / NS);
    bus.start_ns_i[c*32 +: 32]  = 32'(st % NS);
    bus.period_sc_i[c*16 +: 16] = 16'(per / NS);
    bus.period_ns_i[c*30 +: 30] = 30'(per % NS);
    bus.width_ns_i[c*32 +: 32]  = 32'(w);
  endtask
  // Reference model: times as plain ns counts; modes 0 idle, 1 align, 2 armed, 3 high
  always @(posedge rtc_clk or negedge rtc_rst_n) begin
    if (!rtc_rst_n) begin
      for (int c = 0; c < N; c++) begin
        m_mode[c] = 0; m_pulse[c] = 0; m_missed[c] = 0; m_en_prev[c] = 0; m_vld[c] = 0; m_ts[c] = 0;
      end
    end else begin
      longint now;
      now = longint'(bus.rtc_std_i[79:32]) * NS + longint'(bus.rtc_std_i[31:0]);
      for (int c = 0; c < N; c++) begin
        m_vld[c] = 0;
        if (!bus.ch_en_i[c]) begin
          m_mode[c] = 0; m_pulse[c] = 0;
        end else if (m_mode[c] == 0) begin
          if (!m_en_prev[c]) begin
            m_start[c] = longint'(bus.start_sc_i[c*48 +: 48]) * NS + longint'(bus.start_ns_i[c*32 +: 32]);
            m_per[c] = longint'(bus.period_sc_i[c*16 +: 16]) * NS + longint'(bus.period_ns_i[c*30 +: 30]);
            m_w[c] = longint'(bus.width_ns_i[c*32 +: 32]);
            m_tgt[c] = m_start[c]; m_missed[c] = 0; m_mode[c] = 1;
          end
        end else if (bus.rtc_step_i) begin
          m_pulse[c] = 0; m_tgt[c] = m_start[c]; m_mode[c] = 1;
        end else if (m_mode[c] == 1) begin
          if (now >= m_tgt[c]) begin m_tgt[c] += m_per[c]; m_missed[c] = 1; end
          else m_mode[c] = 2;
        end else if (m_mode[c] == 2) begin
          if (now >= m_tgt[c]) begin
            if (m_w[c] != 0) begin
              m_pulse[c] = 1; m_fall[c] = m_tgt[c] + m_w[c]; m_mode[c] = 3; m_vld[c] = 1; m_ts[c] = now;
            end
            m_tgt[c] += m_per[c];
          end
        end else if (now >= m_fall[c] || now >= m_tgt[c]) begin
          m_pulse[c] = 0; m_mode[c] = 2;
        end
        m_en_prev[c] = bus.ch_en_i[c];
      end
    end
  end
  always @(negedge rtc_clk) begin
    for (int c = 0; c < N; c++) begin
      chk($sformatf("pulse%0d", c), 80'(bus.pulse_o[c]), 80'(m_pulse[c]));
      chk($sformatf("align%0d", c), 80'(bus.align_o[c]), 80'(m_mode[c] == 1));
      chk($sformatf("missed%0d", c), 80'(bus.missed_o[c]), 80'(m_missed[c]));
`ifdef RTC_PG_TS_EN
      chk($sformatf("ts_vld%0d", c), 80'(bus.edge_ts_vld_o[c]), 80'(m_vld[c]));
      if (m_vld[c]) chk($sformatf("ts%0d", c), bus.edge_ts_o[c*80 +: 80], to80(m_ts[c]));
`endif
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: no finish, expected end of test");
    $fatal(1);
  end
  initial begin
    longint t;
    bus.rtc_std_i = '0; bus.rtc_step_i = 1'b0; bus.ch_en_i = '0;
    for (int c = 0; c < N; c++) cfg(c, 0, NS, 0);
    tick(0); tick(0);
    chk("rst_pulse", 80'(bus.pulse_o), 80'd0);
    chk("rst_align", 80'(bus.align_o), 80'd0);
    chk("rst_missed", 80'(bus.missed_o), 80'd0);
    rtc_rst_n = 1'b1;
    tick(0);
    // PPS-style channel 0
    cfg(0, 5 * NS, NS, 100_000_000); bus.ch_en_i[0] = 1'b1;
    tick(64'd4_999_999_990); tick(64'd4_999_999_994); tick(64'd4_999_999_998);
    chk("t1_pre", 80'(bus.pulse_o[0]), 80'd0);
    tick(64'd5_000_000_000); chk("t1_rise", 80'(bus.pulse_o[0]), 80'd1);
    tick(64'd5_099_999_996); chk("t1_hold", 80'(bus.pulse_o[0]), 80'd1);
    tick(64'd5_100_000_000); chk("t1_fall", 80'(bus.pulse_o[0]), 80'd0);
    tick(64'd5_999_999_999); chk("t1_gap", 80'(bus.pulse_o[0]), 80'd0);
    tick(64'd6_000_000_000); chk("t1_rise2", 80'(bus.pulse_o[0]), 80'd1);
    chk("t1_missed", 80'(bus.missed_o[0]), 80'd0);
    bus.ch_en_i[0] = 1'b0;
    tick(64'd6_000_000_004); chk("t6_en_drop", 80'(bus.pulse_o[0]), 80'd0);
    // 1 ms period crossing a second boundary
    cfg(1, 64'd999_500_000, 64'd1_000_000, 64'd500_000); bus.ch_en_i[1] = 1'b1;
    tick(64'd999_499_990); tick(64'd999_499_995);
    tick(64'd999_500_000); chk("t2_rise", 80'(bus.pulse_o[1]), 80'd1);
    tick(64'd999_999_999); chk("t2_hold", 80'(bus.pulse_o[1]), 80'd1);
    tick(64'd1_000_000_000); chk("t2_fall", 80'(bus.pulse_o[1]), 80'd0);
    tick(64'd1_000_499_999); chk("t2_gap", 80'(bus.pulse_o[1]), 80'd0);
    tick(64'd1_000_500_000); chk("t2_carry_rise", 80'(bus.pulse_o[1]), 80'd1);
    bus.ch_en_i[1] = 1'b0; tick(64'd1_000_500_004);
    // start already in the past
    cfg(2, 10 * NS, NS, 100_000_000); bus.ch_en_i[2] = 1'b1;
    t = 64'd13_200_000_000;
    repeat (8) begin tick(t); t += 6; end
    chk("t3_missed", 80'(bus.missed_o[2]), 80'd1);
    chk("t3_aligned", 80'(bus.align_o[2]), 80'd0);
    tick(64'd13_999_999_998); chk("t3_pre", 80'(bus.pulse_o[2]), 80'd0);
    tick(64'd14_000_000_000); chk("t3_rise", 80'(bus.pulse_o[2]), 80'd1);
    bus.ch_en_i[2] = 1'b0; tick(64'd14_000_000_004);
    // backward and forward steps
    cfg(3, 0, NS, 500_000_000); bus.ch_en_i[3] = 1'b1;
    t = 64'd12_300_000_000;
    repeat (16) begin tick(t); t += 4; end
    tick(64'd12_999_999_999); chk("t4_pre", 80'(bus.pulse_o[3]), 80'd0);
    tick(64'd13_000_000_000); chk("t4_rise", 80'(bus.pulse_o[3]), 80'd1);
    bus.rtc_step_i = 1'b1; tick(64'd2_300_000_000); bus.rtc_step_i = 1'b0;
    chk("t4_step_low", 80'(bus.pulse_o[3]), 80'd0);
    chk("t4_step_align", 80'(bus.align_o[3]), 80'd1);
    t = 64'd2_300_000_004;
    repeat (6) begin tick(t); t += 4; end
    tick(64'd2_999_999_999); chk("t4_back_pre", 80'(bus.pulse_o[3]), 80'd0);
    tick(64'd3_000_000_000); chk("t4_back_rise", 80'(bus.pulse_o[3]), 80'd1);
    bus.rtc_step_i = 1'b1; tick(64'd7_700_000_000); bus.rtc_step_i = 1'b0;
    chk("t4_fwd_low", 80'(bus.pulse_o[3]), 80'd0);
    t = 64'd7_700_000_004;
    repeat (12) begin tick(t); t += 4; end
    tick(64'd7_999_999_999); chk("t4_fwd_pre", 80'(bus.pulse_o[3]), 80'd0);
    tick(64'd8_000_000_000); chk("t4_fwd_rise", 80'(bus.pulse_o[3]), 80'd1);
    chk("t4_missed", 80'(bus.missed_o[3]), 80'd1);
    bus.ch_en_i[3] = 1'b0; tick(64'd8_000_000_004);
    // zero width never pulses
    cfg(1, 30 * NS, 64'd1_000_000, 0); bus.ch_en_i[1] = 1'b1;
    t = 64'd29_999_999_990;
    repeat (4) begin tick(t); t += 4; end
    tick(64'd30_000_000_000); tick(64'd30_001_000_000); tick(64'd30_002_000_000);
    chk("t5_w0", 80'(bus.pulse_o[1]), 80'd0);
    bus.ch_en_i[1] = 1'b0; tick(64'd30_002_000_004);
    // width longer than period: one low cycle per boundary
    cfg(0, 20 * NS, NS, 2 * NS); bus.ch_en_i[0] = 1'b1;
    tick(64'd19_999_999_990); tick(64'd19_999_999_994); tick(64'd19_999_999_998);
    tick(64'd20_000_000_000); chk("t5_rise", 80'(bus.pulse_o[0]), 80'd1);
    tick(64'd20_500_000_000); chk("t5_hold", 80'(bus.pulse_o[0]), 80'd1);
    tick(64'd20_999_999_999); chk("t5_hold2", 80'(bus.pulse_o[0]), 80'd1);
    tick(64'd21_000_000_000); chk("t5_gap", 80'(bus.pulse_o[0]), 80'd0);
    tick(64'd21_000_000_004); chk("t5_rerise", 80'(bus.pulse_o[0]), 80'd1);
    tick(64'd21_999_999_999); chk("t5_hold3", 80'(bus.pulse_o[0]), 80'd1);
    tick(64'd22_000_000_000); chk("t5_gap2", 80'(bus.pulse_o[0]), 80'd0);
    tick(64'd22_000_000_004); chk("t5_rerise2", 80'(bus.pulse_o[0]), 80'd1);
    // asynchronous reset mid-pulse
    rtc_rst_n = 1'b0;
    #1;
    chk("t6_rst_pulse", 80'(bus.pulse_o), 80'd0);
    chk("t6_rst_missed", 80'(bus.missed_o), 80'd0);
    chk("t6_rst_align", 80'(bus.align_o), 80'd0);
    tick(64'd22_000_000_008);
    rtc_rst_n = 1'b1;
    tick(64'd22_000_000_012); tick(64'd22_000_000_016);
    chk("t6_post_rst", 80'(bus.pulse_o[0]), 80'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
